// File: rtl/cheri_mem_lane_steer.sv
// Lane-steering adapter between a 32-bit+tag CHERIoT core port and a MemLanes*32+tag memory port.
// Optional occupancy/stall statistics are built when CHERI_LANE_STATS_EN is defined.
module cheri_mem_lane_steer #(
    parameter int unsigned MemLanes         = 2,
    parameter int unsigned OutstandingDepth = 2,
    parameter int unsigned TagEn            = 1
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    core_req_i,
    output logic                    core_gnt_o,
    input  logic                    core_we_i,
    input  logic [3:0]              core_be_i,
    input  logic [31:0]             core_addr_i,
    input  logic [32:0]             core_wdata_i,
    output logic                    core_rvalid_o,
    output logic [32:0]             core_rdata_o,
    output logic                    core_err_o,
    output logic                    mem_req_o,
    input  logic                    mem_gnt_i,
    output logic                    mem_we_o,
    output logic [MemLanes*4-1:0]   mem_be_o,
    output logic [31:0]             mem_addr_o,
    output logic [MemLanes*32:0]    mem_wdata_o,
    input  logic                    mem_rvalid_i,
    input  logic [MemLanes*32:0]    mem_rdata_i,
    input  logic                    mem_err_i,
    output logic [3:0]              outstanding_o,
    output logic                    unexp_rsp_o
`ifdef CHERI_LANE_STATS_EN
    ,
    output logic [3:0]              hiwater_o,
    output logic [15:0]             stall_cnt_o
`endif
);

    localparam int unsigned MemW     = MemLanes * 32;
    localparam int unsigned BeW      = MemLanes * 4;
    localparam int unsigned LaneIdxW = (MemLanes > 1) ? $clog2(MemLanes) : 1;
    localparam int unsigned PtrW     = (OutstandingDepth > 1) ? $clog2(OutstandingDepth) : 1;
    localparam logic [3:0]      DepthCnt = 4'(OutstandingDepth);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(OutstandingDepth - 1);

    logic [LaneIdxW-1:0] req_lane;
    logic [LaneIdxW-1:0] head_lane;
    logic [LaneIdxW-1:0] lane_fifo_q [OutstandingDepth];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [3:0]          count_q, count_d;
    logic                unexp_q, unexp_d;
    logic                full, empty, push, pop;
    logic [31:0]         rdata_lane;
    logic                rdata_tag;
    logic                wdata_tag;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : PtrW'(p + 1'b1);
    endfunction

    always_comb begin
        req_lane = '0;
        if (MemLanes > 1) begin
            req_lane = core_addr_i[2 +: LaneIdxW];
        end
    end

    // Request path: gating on registered full keeps the grant free of any pop in this cycle.
    assign full       = (count_q == DepthCnt);
    assign empty      = (count_q == '0);
    assign mem_req_o  = core_req_i & ~full;
    assign core_gnt_o = mem_gnt_i & ~full;
    assign push       = mem_req_o & mem_gnt_i;
    assign pop        = mem_rvalid_i & ~empty;

    assign mem_we_o    = core_we_i;
    assign mem_addr_o  = core_addr_i;
    assign mem_be_o    = BeW'(core_be_i) << {req_lane, 2'b00};
    assign wdata_tag   = (TagEn != 0) ? core_wdata_i[32] : 1'b0;
    assign mem_wdata_o = {wdata_tag, {MemLanes{core_wdata_i[31:0]}}};

    // Response path: an unexpected response falls back to lane 0.
    assign head_lane = empty ? '0 : lane_fifo_q[rd_ptr_q];

    always_comb begin
        rdata_lane = '0;
        for (int unsigned i = 0; i < MemLanes; i++) begin
            if (head_lane == LaneIdxW'(i)) begin
                rdata_lane = mem_rdata_i[i*32 +: 32];
            end
        end
    end

    assign rdata_tag     = (TagEn != 0) && (head_lane == '0) ? mem_rdata_i[MemW] : 1'b0;
    assign core_rdata_o  = {rdata_tag, rdata_lane};
    assign core_rvalid_o = mem_rvalid_i;
    assign core_err_o    = mem_err_i;

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 4'd1;
            2'b01:   count_d = count_q - 4'd1;
            default: count_d = count_q;
        endcase
        unexp_d = unexp_q | (mem_rvalid_i & empty);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            unexp_q  <= 1'b0;
            for (int unsigned i = 0; i < OutstandingDepth; i++) begin
                lane_fifo_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            unexp_q  <= unexp_d;
            if (push) begin
                lane_fifo_q[wr_ptr_q] <= req_lane;
            end
        end
    end

    assign outstanding_o = count_q;
    assign unexp_rsp_o   = unexp_q;

`ifdef CHERI_LANE_STATS_EN
    logic [3:0]  hiwater_q;
    logic [15:0] stall_cnt_q;

    // Hiwater tracks next-state occupancy so a peak shows up on the edge it is reached.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hiwater_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (count_d > hiwater_q) begin
                hiwater_q <= count_d;
            end
            if (core_req_i && full && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign hiwater_o   = hiwater_q;
    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cheri_mem_lane_steer.sv
// Scoreboard bench for cheri_mem_lane_steer with MemLanes=2, OutstandingDepth=2, TagEn=1.
module tb_cheri_mem_lane_steer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        core_req, core_we, mem_gnt, mem_rvalid, mem_err;
    logic [3:0]  core_be;
    logic [31:0] core_addr;
    logic [32:0] core_wdata;
    logic [64:0] mem_rdata;
    logic        core_gnt_o, core_rvalid_o, core_err_o;
    logic [32:0] core_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [7:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [64:0] mem_wdata_o;
    logic [3:0]  outstanding_o;
    logic        unexp_rsp_o;
`ifdef CHERI_LANE_STATS_EN
    logic [3:0]  hiwater_o;
    logic [15:0] stall_cnt_o;
`endif

    int total = 0;
    int bad   = 0;
    logic [64:0] rsp_q [$];
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    cheri_mem_lane_steer #(
        .MemLanes(2),
        .OutstandingDepth(2),
        .TagEn(1)
    ) dut (
        .clk_i(clk), .rstn_i(rstn),
        .core_req_i(core_req), .core_gnt_o(core_gnt_o), .core_we_i(core_we),
        .core_be_i(core_be), .core_addr_i(core_addr), .core_wdata_i(core_wdata),
        .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
        .outstanding_o(outstanding_o), .unexp_rsp_o(unexp_rsp_o)
`ifdef CHERI_LANE_STATS_EN
        , .hiwater_o(hiwater_o), .stall_cnt_o(stall_cnt_o)
`endif
    );

    // Expected steered read: lane from addr[2]; tag only survives on lane 0.
    function automatic logic [32:0] exp_of(input logic [31:0] addr, input logic [64:0] rsp);
        logic [32:0] r;
        if (addr[2]) r = {1'b0, rsp[63:32]};
        else         r = {rsp[64], rsp[31:0]};
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [31:0] addr, input logic [64:0] rsp);
        rsp_q.push_back(rsp);
        exp_q.push_back(exp_of(addr, rsp));
    endtask

    task automatic test_reset;
        rstn = 1'b0; core_req = 1'b1; core_we = 1'b0; core_be = 4'hF;
        core_addr = 32'h4; core_wdata = '0; mem_gnt = 1'b1;
        mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
        #2;
        total++; if (outstanding_o !== 4'd0) begin bad++; $display("FAIL rst_outstanding got=%0d exp=0", outstanding_o); end
        total++; if (unexp_rsp_o !== 1'b0) begin bad++; $display("FAIL rst_unexp got=%0b exp=0", unexp_rsp_o); end
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL rst_mem_req got=%0b exp=1", mem_req_o); end
        total++; if (core_gnt_o !== 1'b1) begin bad++; $display("FAIL rst_gnt got=%0b exp=1", core_gnt_o); end
        total++; if (mem_be_o !== 8'hF0) begin bad++; $display("FAIL rst_be got=%h exp=f0", mem_be_o); end
        core_req = 1'b0; mem_gnt = 1'b0;
        tick;
        rstn = 1'b1;
        tick;
    endtask

    task automatic test_byte_write;
        core_req = 1'b1; core_we = 1'b1; core_be = 4'b0011;
        core_addr = 32'h2000_0004; core_wdata = 33'h0_1234_5678; mem_gnt = 1'b0;
        #1;
        total++; if (mem_be_o !== 8'b0011_0000) begin bad++; $display("FAIL bw_be got=%b exp=00110000", mem_be_o); end
        total++; if (mem_wdata_o !== 65'h0_1234_5678_1234_5678) begin bad++; $display("FAIL bw_wdata got=%h exp=012345678_12345678", mem_wdata_o); end
        total++; if (mem_addr_o !== 32'h2000_0004) begin bad++; $display("FAIL bw_addr got=%h exp=20000004", mem_addr_o); end
        total++; if (mem_we_o !== 1'b1) begin bad++; $display("FAIL bw_we got=%0b exp=1", mem_we_o); end
        core_wdata = 33'h1_DEAD_BEEF; core_addr = 32'h0; core_be = 4'b1000;
        #1;
        total++; if (mem_wdata_o !== 65'h1_DEAD_BEEF_DEAD_BEEF) begin bad++; $display("FAIL bw_tag_wdata got=%h exp=1deadbeefdeadbeef", mem_wdata_o); end
        total++; if (mem_be_o !== 8'b0000_1000) begin bad++; $display("FAIL bw_be_lane0 got=%b exp=00001000", mem_be_o); end
        core_req = 1'b0; core_we = 1'b0;
        tick;
        total++; if (outstanding_o !== 4'd0) begin bad++; $display("FAIL bw_no_push got=%0d exp=0", outstanding_o); end
    endtask

    task automatic test_back_to_back;
        logic [64:0] r;
        logic [32:0] e;
        core_req = 1'b1; core_we = 1'b0; core_be = 4'hF; mem_gnt = 1'b1;
        core_addr = 32'h1000_0000;
        sb_push(core_addr, 65'h1_AAAA_BBBB_CCCC_DDDD);
        #1;
        total++; if (core_gnt_o !== 1'b1) begin bad++; $display("FAIL b2b_gnt0 got=%0b exp=1", core_gnt_o); end
        tick;
        core_addr = 32'h1000_0004;
        sb_push(core_addr, 65'h1_AAAA_BBBB_CCCC_DDDD);
        #1;
        total++; if (core_gnt_o !== 1'b1) begin bad++; $display("FAIL b2b_gnt1 got=%0b exp=1", core_gnt_o); end
        tick;
        core_req = 1'b0;
        total++; if (outstanding_o !== 4'd2) begin bad++; $display("FAIL b2b_occ got=%0d exp=2", outstanding_o); end
        for (int i = 0; i < 2; i++) begin
            r = rsp_q.pop_front(); e = exp_q.pop_front();
            mem_rvalid = 1'b1; mem_rdata = r;
            #1;
            total++; if (core_rdata_o !== e) begin bad++; $display("FAIL b2b_rdata%0d got=%h exp=%h", i, core_rdata_o, e); end
            total++; if (core_rvalid_o !== 1'b1) begin bad++; $display("FAIL b2b_rvalid%0d got=%0b exp=1", i, core_rvalid_o); end
            tick;
        end
        mem_rvalid = 1'b0;
        total++; if (outstanding_o !== 4'd0) begin bad++; $display("FAIL b2b_drain got=%0d exp=0", outstanding_o); end
    endtask

    task automatic test_full;
        logic [64:0] r;
        logic [32:0] e;
        core_req = 1'b1; core_we = 1'b0; mem_gnt = 1'b1;
        core_addr = 32'h8;  sb_push(core_addr, 65'h1_1111_1111_2222_2222); tick;
        core_addr = 32'hC;  sb_push(core_addr, 65'h0_3333_3333_4444_4444); tick;
        core_addr = 32'h14;
        #1;
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL full_req got=%0b exp=0", mem_req_o); end
        total++; if (core_gnt_o !== 1'b0) begin bad++; $display("FAIL full_gnt got=%0b exp=0", core_gnt_o); end
        total++; if (outstanding_o !== 4'd2) begin bad++; $display("FAIL full_occ got=%0d exp=2", outstanding_o); end
        tick;
        r = rsp_q.pop_front(); e = exp_q.pop_front();
        mem_rvalid = 1'b1; mem_rdata = r;
        #1;
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL full_nobypass got=%0b exp=0", mem_req_o); end
        total++; if (core_rdata_o !== e) begin bad++; $display("FAIL full_rdata got=%h exp=%h", core_rdata_o, e); end
        tick;
        mem_rvalid = 1'b0;
        sb_push(core_addr, 65'h1_5555_5555_6666_6666);
        #1;
        total++; if (core_gnt_o !== 1'b1) begin bad++; $display("FAIL full_regrant got=%0b exp=1", core_gnt_o); end
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL full_rereq got=%0b exp=1", mem_req_o); end
        tick;
        core_req = 1'b0;
        total++; if (outstanding_o !== 4'd2) begin bad++; $display("FAIL full_refill got=%0d exp=2", outstanding_o); end
        for (int i = 0; i < 2; i++) begin
            r = rsp_q.pop_front(); e = exp_q.pop_front();
            mem_rvalid = 1'b1; mem_rdata = r;
            #1;
            total++; if (core_rdata_o !== e) begin bad++; $display("FAIL full_drain%0d got=%h exp=%h", i, core_rdata_o, e); end
            tick;
        end
        mem_rvalid = 1'b0;
    endtask

    task automatic test_push_pop;
        logic [31:0] a;
        logic [64:0] r, cur;
        logic [32:0] e;
        core_req = 1'b1; core_we = 1'b0; mem_gnt = 1'b1;
        core_addr = 32'h40;
        sb_push(core_addr, {1'($urandom), $urandom, $urandom});
        tick;
        total++; if (outstanding_o !== 4'd1) begin bad++; $display("FAIL pp_prime got=%0d exp=1", outstanding_o); end
        for (int i = 0; i < 20; i++) begin
            a = $urandom; a[1:0] = 2'b00;
            r = {1'($urandom), $urandom, $urandom};
            cur = rsp_q.pop_front(); e = exp_q.pop_front();
            core_addr = a; core_we = 1'($urandom_range(0, 1)); core_be = 4'($urandom_range(1, 15));
            mem_rvalid = 1'b1; mem_rdata = cur;
            sb_push(a, r);
            #1;
            total++; if (core_rdata_o !== e) begin bad++; $display("FAIL pp_rdata%0d got=%h exp=%h", i, core_rdata_o, e); end
            total++; if (core_gnt_o !== 1'b1) begin bad++; $display("FAIL pp_gnt%0d got=%0b exp=1", i, core_gnt_o); end
            tick;
            total++; if (outstanding_o !== 4'd1) begin bad++; $display("FAIL pp_occ%0d got=%0d exp=1", i, outstanding_o); end
        end
        core_req = 1'b0; core_we = 1'b0;
        cur = rsp_q.pop_front(); e = exp_q.pop_front();
        mem_rdata = cur;
        #1;
        total++; if (core_rdata_o !== e) begin bad++; $display("FAIL pp_last got=%h exp=%h", core_rdata_o, e); end
        tick;
        mem_rvalid = 1'b0;
        total++; if (outstanding_o !== 4'd0) begin bad++; $display("FAIL pp_drain got=%0d exp=0", outstanding_o); end
    endtask

    task automatic test_unexpected;
        mem_rvalid = 1'b1; mem_err = 1'b1;
        mem_rdata = 65'h1_0000_0001_0000_0002;
        #1;
        total++; if (core_rdata_o !== 33'h1_0000_0002) begin bad++; $display("FAIL ux_lane0 got=%h exp=100000002", core_rdata_o); end
        total++; if (core_err_o !== 1'b1) begin bad++; $display("FAIL ux_err got=%0b exp=1", core_err_o); end
        tick;
        mem_rvalid = 1'b0; mem_err = 1'b0;
        total++; if (unexp_rsp_o !== 1'b1) begin bad++; $display("FAIL ux_set got=%0b exp=1", unexp_rsp_o); end
        total++; if (outstanding_o !== 4'd0) begin bad++; $display("FAIL ux_occ got=%0d exp=0", outstanding_o); end
        repeat (3) tick;
        total++; if (unexp_rsp_o !== 1'b1) begin bad++; $display("FAIL ux_sticky got=%0b exp=1", unexp_rsp_o); end
    endtask

    task automatic test_reset_mid;
        core_req = 1'b1; mem_gnt = 1'b1;
        core_addr = 32'h100; tick;
        core_addr = 32'h104; tick;
        core_req = 1'b0;
        total++; if (outstanding_o !== 4'd2) begin bad++; $display("FAIL rm_pre got=%0d exp=2", outstanding_o); end
        #1 rstn = 1'b0;
        #1;
        total++; if (outstanding_o !== 4'd0) begin bad++; $display("FAIL rm_occ got=%0d exp=0", outstanding_o); end
        total++; if (unexp_rsp_o !== 1'b0) begin bad++; $display("FAIL rm_unexp got=%0b exp=0", unexp_rsp_o); end
        tick;
        rstn = 1'b1;
        rsp_q.delete(); exp_q.delete();
        mem_rvalid = 1'b1; mem_rdata = 65'h0_0BAD_0BAD_0BAD_0BAD;
        tick;
        mem_rvalid = 1'b0;
        total++; if (unexp_rsp_o !== 1'b1) begin bad++; $display("FAIL rm_inflight got=%0b exp=1", unexp_rsp_o); end
        total++; if (outstanding_o !== 4'd0) begin bad++; $display("FAIL rm_occ_after got=%0d exp=0", outstanding_o); end
    endtask

`ifdef CHERI_LANE_STATS_EN
    task automatic test_stats;
        rstn = 1'b0; #1 rstn = 1'b1;
        tick;
        core_req = 1'b1; mem_gnt = 1'b1; core_addr = 32'h0;
        tick; tick;
        repeat (5) tick;
        core_req = 1'b0;
        #1;
        total++; if (stall_cnt_o !== 16'd5) begin bad++; $display("FAIL st_stall got=%0d exp=5", stall_cnt_o); end
        total++; if (hiwater_o !== 4'd2) begin bad++; $display("FAIL st_hiwater got=%0d exp=2", hiwater_o); end
        mem_rvalid = 1'b1; tick; tick; mem_rvalid = 1'b0;
    endtask
`endif

    initial begin
        test_reset;
        test_byte_write;
        test_back_to_back;
        test_full;
        test_push_pop;
        test_unexpected;
        test_reset_mid;
`ifdef CHERI_LANE_STATS_EN
        test_stats;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cheri_mem_lane_steer.md
Name: cheri_mem_lane_steer

Overview:
- Parametrised lane-steering adapter between a CHERIoT core port (32-bit lane plus tag) and a wider memory port (MemLanes*32 data plus tag).
- Instantiated once per core memory interface (instr, data, tsmap) in the core wrapper.
- Tracks up to OutstandingDepth in-flight requests in a lane-select FIFO, so pipelined requests return correctly steered data.
- Steers write data and byte enables into the addressed lane.

Parameters:
MemLanes, 2, number of 32-bit lanes in the memory word; legal values 1, 2, 4.
OutstandingDepth, 2, max in-flight requests; legal values 1..8.
TagEn, 1, 1 = bit [MemLanes*32] of the memory word is the capability tag; 0 = no tag, tag outputs tie to 0.

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
core_req_i  in  1  core request
core_gnt_o  out  1  grant to core
core_we_i  in  1  write enable
core_be_i  in  4  byte enables
core_addr_i  in  32  byte address
core_wdata_i  in  33  write data; bit 32 = tag
core_rvalid_o  out  1  read/write response valid
core_rdata_o  out  33  steered read data; bit 32 = tag
core_err_o  out  1  response error
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory grant
mem_we_o  out  1  write enable
mem_be_o  out  MemLanes*4  lane-positioned byte enables
mem_addr_o  out  32  address, passed through unchanged
mem_wdata_o  out  MemLanes*32+1  replicated write data plus tag
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  MemLanes*32+1  memory read data
mem_err_i  in  1  memory response error
outstanding_o  out  4  current FIFO occupancy
unexp_rsp_o  out  1  sticky: response arrived with FIFO empty

Behaviour:
- Lane index: L = core_addr_i[LW+1:2], where LW = log2(MemLanes). L = 0 when MemLanes = 1.
- Request path (combinational):
  - mem_req_o = core_req_i & !full.
  - core_gnt_o = mem_gnt_i & !full. full is registered occupancy == OutstandingDepth.
  - mem_we_o and mem_addr_o pass through.
  - mem_be_o = core_be_i << (4*L).
  - mem_wdata_o = core_wdata_i[31:0] replicated MemLanes times, with tag = core_wdata_i[32] at the MSB.
- Lane FIFO:
  - Push L when mem_req_o & mem_gnt_i. Pop when mem_rvalid_i & !empty.
  - Push and pop in the same cycle: occupancy unchanged, both take effect.
  - At full, push is impossible because the request is gated. A pop at full frees the slot for the next cycle only; no same-cycle bypass.
  - Pointers wrap modulo OutstandingDepth. Occupancy counter is 4 bits wide.
- Response path (combinational from FIFO head):
  - core_rvalid_o = mem_rvalid_i.
  - core_rdata_o[31:0] = mem_rdata_i lane H (H = FIFO head).
  - core_rdata_o[32] = mem_rdata_i tag when H == 0 and TagEn = 1; otherwise 0. A tag is valid only on the cap-aligned lane.
  - core_err_o = mem_err_i.
  - rvalid with FIFO empty: H = 0 is used, unexp_rsp_o sets and stays set until reset, occupancy stays 0.
- Reset (asynchronous, any time including mid-transaction):
  - FIFO pointers and occupancy clear to 0; unexp_rsp_o = 0.
  - Responses in flight at reset are treated as unexpected after reset deasserts.
- Reset values of outputs:
  - Occupancy-derived and sticky outputs (outstanding_o, unexp_rsp_o) = 0.
  - Combinational outputs follow the inputs, with full = 0.
- Latency: zero added cycles on both request and response paths.

Optional Feature:
CHERI_LANE_STATS_EN
- Defined: adds output hiwater_o [3:0], the maximum occupancy reached since reset, and output stall_cnt_o [15:0], the count of cycles with core_req_i & full, saturating at 16'hFFFF. Both reset to 0.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
- Byte write (MemLanes=2): we=1, be=4'b0011, addr=32'h2000_0004, wdata=33'h0_1234_5678 -> mem_be_o=8'b0011_0000, mem_wdata_o=65'h0_1234_5678_1234_5678.
- Two reads back-to-back: addr 0x...0 then 0x...4, both granted, responses 65'h1_AAAA_BBBB_CCCC_DDDD each -> core_rdata_o=33'h1_CCCC_DDDD then 33'h0_AAAA_BBBB.
- Depth=2: three requests with no responses -> third request sees mem_req_o=0, core_gnt_o=0, outstanding_o=2. One response -> third request granted the next cycle.
- Simultaneous push and pop at occupancy 1 -> occupancy stays 1, data still steered in order over 20 random transactions.
- rvalid with FIFO empty -> unexp_rsp_o=1 persists, outstanding_o=0. Reset pulse mid-burst with 2 outstanding -> outstanding_o=0, unexp_rsp_o=0.
- With CHERI_LANE_STATS_EN: 5 stalled cycles -> stall_cnt_o=5, hiwater_o=2.
